// File: rtl/spi_slave_pkg.sv
// Shared definitions for the APB SPI slave: register word offsets (PADDR[3:2]),
// STATUS/CTRL bit positions, FSM state encoding and the underflow fill byte.
package spi_slave_pkg;
  // Word offsets decoded from PADDR[3:2]
  localparam logic [1:0] ADDR_STATUS = 2'd0; // 0x0
  localparam logic [1:0] ADDR_TXDATA = 2'd1; // 0x4
  localparam logic [1:0] ADDR_RXDATA = 2'd2; // 0x8
  localparam logic [1:0] ADDR_CTRL   = 2'd3; // 0xC

  localparam int STAT_BUSY      = 0;
  localparam int STAT_RXOVF     = 1;
  localparam int STAT_TXUDF     = 2;
  localparam int STAT_ABORT     = 3;
  localparam int STAT_TXOVF     = 4;
  localparam int STAT_TXCNT_LSB = 8;
  localparam int STAT_RXCNT_LSB = 16;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_SWRST     = 1;
  localparam int CTRL_RXIE      = 2;
  localparam int CTRL_TXIE      = 3;
  localparam int CTRL_RXTH_LSB  = 4;
  localparam int CTRL_TXTH_LSB  = 12;

  // Shifted out when the master clocks a byte and the TX FIFO is empty
  localparam logic [7:0] UDF_FILL = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} spi_state_e;
endpackage

// File: rtl/spi_slave_fifo.sv
// Byte FIFO with valid/ready on both sides.
// Ports: clk_i/rst_ni (async active-low), clr_i (sync flush, beats push/pop),
//   in_valid_i/in_ready_o/in_data_i push side, out_valid_o/out_ready_i/out_data_o
//   pop side, elements_o current fill level.
// A full FIFO still accepts a push in a cycle where it is also popped.
module spi_slave_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [7:0]    in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [7:0]    out_data_o,
  output logic [CW-1:0] elements_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  assign out_valid_o = (cnt_q != '0);
  assign in_ready_o  = (cnt_q != CW'(DEPTH)) | out_ready_i;
  assign push        = in_valid_i & in_ready_o & ~clr_i;
  assign pop         = out_ready_i & out_valid_o & ~clr_i;
  assign out_data_o  = mem_q[rptr_q];
  assign elements_o  = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= in_data_i;
  end
endmodule

// File: rtl/apb_spi_slave.sv
// APB-programmed SPI slave (mode 0, MSB first, 8-bit frames) with TX/RX byte FIFOs.
// Ports: HCLK/HRESETn (async active-low), APB slave (PADDR, PWDATA, PWRITE, PSEL,
//   PENABLE, PRDATA, PREADY=1, PSLVERR=0), events_o interrupt, SPI pins
//   spi_sclk/spi_csn/spi_sdi in, spi_sdo/spi_oe out.
// Optional: define SPI_SLAVE_IRQ_EN to build the FIFO-threshold interrupt and the
//   CTRL[19:2] fields; otherwise events_o is 0 and those CTRL bits read 0.
import spi_slave_pkg::*;

module apb_spi_slave #(
  parameter int unsigned BUFFER_DEPTH   = 8,
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      events_o,
  input  logic                      spi_sclk,
  input  logic                      spi_csn,
  input  logic                      spi_sdi,
  output logic                      spi_sdo,
  output logic                      spi_oe
);
  localparam int unsigned CW = $clog2(BUFFER_DEPTH) + 1;

  // ---------------- pin synchronizers ([1] = synced, [2] = edge-detect) -----
  logic [2:0] sclk_q, csn_q;
  logic [1:0] sdi_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sclk_q <= 3'b000;
      csn_q  <= 3'b111;
      sdi_q  <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      csn_q  <= {csn_q[1:0], spi_csn};
      sdi_q  <= {sdi_q[0], spi_sdi};
    end
  end
  logic sclk_rise, sclk_fall, csn_fall, csn_rise, sdi_s;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign csn_fall  = ~csn_q[1] & csn_q[2];
  assign csn_rise  = csn_q[1] & ~csn_q[2];
  assign sdi_s     = sdi_q[1];

  // ---------------- APB decode ----------------------------------------------
  logic [1:0] reg_sel;
  logic apb_wr, apb_rd, wr_ctrl, wr_stat, wr_tx, rd_rx;
  assign reg_sel = PADDR[3:2];
  assign apb_wr  = PSEL & PENABLE & PWRITE;
  assign apb_rd  = PSEL & PENABLE & ~PWRITE;
  assign wr_ctrl = apb_wr & (reg_sel == ADDR_CTRL);
  assign wr_stat = apb_wr & (reg_sel == ADDR_STATUS);
  assign wr_tx   = apb_wr & (reg_sel == ADDR_TXDATA);
  assign rd_rx   = apb_rd & (reg_sel == ADDR_RXDATA);

  logic unused_apb;
  assign unused_apb = ^{PADDR, PWDATA};

  // ---------------- CTRL ----------------------------------------------------
  logic en_q, swrst_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q    <= 1'b0;
      swrst_q <= 1'b0;
    end else begin
      swrst_q <= wr_ctrl & PWDATA[CTRL_SWRST];
      if (wr_ctrl) en_q <= PWDATA[CTRL_EN];
    end
  end

  // ---------------- FIFOs ---------------------------------------------------
  logic          tx_in_rdy, tx_valid, tx_pop, rx_in_rdy, rx_valid, rx_push;
  logic [7:0]    tx_data, rx_data, rx_byte;
  logic [CW-1:0] tx_cnt, rx_cnt;

  spi_slave_fifo #(.DEPTH(BUFFER_DEPTH)) u_tx_fifo (
    .clk_i(HCLK), .rst_ni(HRESETn), .clr_i(swrst_q),
    .in_valid_i(wr_tx), .in_ready_o(tx_in_rdy), .in_data_i(PWDATA[7:0]),
    .out_valid_o(tx_valid), .out_ready_i(tx_pop), .out_data_o(tx_data),
    .elements_o(tx_cnt)
  );

  spi_slave_fifo #(.DEPTH(BUFFER_DEPTH)) u_rx_fifo (
    .clk_i(HCLK), .rst_ni(HRESETn), .clr_i(swrst_q),
    .in_valid_i(rx_push), .in_ready_o(rx_in_rdy), .in_data_i(rx_byte),
    .out_valid_o(rx_valid), .out_ready_i(rd_rx), .out_data_o(rx_data),
    .elements_o(rx_cnt)
  );

  // ---------------- shift FSM -----------------------------------------------
  spi_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] rxsh_q, rxsh_d;
  logic [7:0] txsh_q, txsh_d;
  logic       reload_q, reload_d; // byte boundary seen, next fall reloads txsh
  logic       load, set_udf, set_abort;

  assign rx_byte = {rxsh_q, sdi_s};

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    rxsh_d    = rxsh_q;
    txsh_d    = txsh_q;
    reload_d  = reload_q;
    load      = 1'b0;
    rx_push   = 1'b0;
    set_abort = 1'b0;
    if (swrst_q) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      reload_d = 1'b0;
    end else if (state_q != ST_IDLE && (!en_q || csn_rise)) begin
      state_d   = ST_IDLE;
      set_abort = (bitcnt_q != 3'd0);
      bitcnt_d  = '0;
      reload_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (csn_fall && en_q) state_d = ST_LOAD;
        ST_LOAD: begin
          load     = 1'b1;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rxsh_d   = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_push  = 1'b1;
              reload_d = 1'b1;
            end
          end else if (sclk_fall) begin
            if (reload_q) begin
              load     = 1'b1;
              reload_d = 1'b0;
            end else begin
              txsh_d = {txsh_q[6:0], 1'b0};
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // LOAD action; an empty FIFO (even with a same-cycle APB push) underflows
    tx_pop  = load;
    set_udf = load & ~tx_valid;
    if (load) txsh_d = tx_valid ? tx_data : UDF_FILL;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      rxsh_q   <= '0;
      txsh_q   <= '0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rxsh_q   <= rxsh_d;
      txsh_q   <= txsh_d;
      reload_q <= reload_d;
    end
  end

  assign spi_oe  = (state_q != ST_IDLE);
  assign spi_sdo = spi_oe & txsh_q[7];

  // ---------------- sticky flags, STATUS[4:1] = {tx_ovf, abort, tx_udf, rx_ovf}
  logic [3:0] flags_q, flags_set, flags_clr;
  assign flags_set = {wr_tx & ~tx_in_rdy, set_abort, set_udf, rx_push & ~rx_in_rdy};
  assign flags_clr = wr_stat ? PWDATA[STAT_TXOVF:STAT_RXOVF] : 4'h0;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     flags_q <= '0;
    else if (swrst_q) flags_q <= '0;
    else              flags_q <= (flags_q & ~flags_clr) | flags_set;
  end

  // ---------------- optional threshold interrupt -----------------------------
  logic [31:0] ctrl_rd;
`ifdef SPI_SLAVE_IRQ_EN
  logic       rxie_q, txie_q, events_q;
  logic [7:0] rxth_q, txth_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rxie_q   <= 1'b0;
      txie_q   <= 1'b0;
      rxth_q   <= '0;
      txth_q   <= '0;
      events_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rxie_q <= PWDATA[CTRL_RXIE];
        txie_q <= PWDATA[CTRL_TXIE];
        rxth_q <= PWDATA[CTRL_RXTH_LSB +: 8];
        txth_q <= PWDATA[CTRL_TXTH_LSB +: 8];
      end
      events_q <= (rxie_q & (8'(rx_cnt) > rxth_q)) | (txie_q & (8'(tx_cnt) < txth_q));
    end
  end
  assign events_o = events_q;
  assign ctrl_rd  = {12'h0, txth_q, rxth_q, txie_q, rxie_q, swrst_q, en_q};
`else
  assign events_o = 1'b0;
  assign ctrl_rd  = {30'h0, swrst_q, en_q};
`endif

  // ---------------- read mux (valid only in the access phase) ---------------
  always_comb begin
    PRDATA = '0;
    if (apb_rd) begin
      case (reg_sel)
        ADDR_STATUS: PRDATA = {8'h0, 8'(rx_cnt), 8'(tx_cnt), 3'b0, flags_q,
                               ~csn_q[1] & en_q};
        ADDR_RXDATA: PRDATA = rx_valid ? {24'h0, rx_data} : 32'h0;
        ADDR_CTRL:   PRDATA = ctrl_rd;
        default:     PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
endmodule

// File: tb/tb_apb_spi_slave.sv
module tb_apb_spi_slave;
  localparam int DEPTH = 8;
  localparam int HALF  = 8; // HCLK cycles per sclk half period
`ifdef SPI_SLAVE_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic        PREADY, PSLVERR, events_o;
  logic        spi_sclk = 1'b0, spi_csn = 1'b1, spi_sdi = 1'b0;
  logic        spi_sdo, spi_oe;

  int n_checks = 0, n_fail = 0, ev_hi = 0;

  // Reference model: byte queues plus sticky flags {tx_ovf, abort, tx_udf, rx_ovf}
  logic [7:0] txq[$], rxq[$], mosi_q[$], miso_q[$], exp_q[$];
  logic [3:0] mflags = '0;

  always #5 HCLK = ~HCLK;
  always @(negedge HCLK) if (events_o === 1'b1) ev_hi++;

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  apb_spi_slave #(.BUFFER_DEPTH(DEPTH), .APB_ADDR_WIDTH(12)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .events_o(events_o),
    .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_oe(spi_oe)
  );

  // ---------------- model ---------------------------------------------------
  function automatic logic [7:0] m_load();
    if (txq.size() > 0) return txq.pop_front();
    mflags[1] = 1'b1;
    return 8'hFF;
  endfunction

  function automatic void m_rx_push(input logic [7:0] b);
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else mflags[0] = 1'b1;
  endfunction

  function automatic logic [7:0] m_rx_pop();
    if (rxq.size() > 0) return rxq.pop_front();
    return 8'h00;
  endfunction

  // A frame loads a byte at csn fall and again after every completed byte.
  function automatic void m_frame(input int n, input int part);
    logic [7:0] cur;
    exp_q.delete();
    cur = m_load();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(cur);
      m_rx_push(mosi_q[i]);
      cur = m_load();
    end
    if (part > 0) begin
      exp_q.push_back(cur);
      mflags[2] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] m_status();
    return {8'h0, 8'(rxq.size()), 8'(txq.size()), 3'b0, mflags, 1'b0};
  endfunction

  function automatic void m_clear();
    txq.delete(); rxq.delete(); mflags = '0;
  endfunction

  // ---------------- drivers -------------------------------------------------
  task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    PADDR = {8'($urandom), a, 2'b00}; PWDATA = d;
    @(negedge HCLK); PENABLE = 1'b1;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge HCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
    PADDR = {8'($urandom), a, 2'b00};
    @(negedge HCLK); PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge HCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    apb_write(2'd1, {24'($urandom), b});
    if (txq.size() < DEPTH) txq.push_back(b);
    else mflags[3] = 1'b1;
  endtask

  task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_sdi = mosi[7-i];
      repeat (HALF) @(negedge HCLK);
      miso[7-i] = spi_sdo;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge HCLK);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge HCLK);
    spi_csn = 1'b1;
    repeat (8) @(negedge HCLK);
  endtask

  // n full bytes then an optional partial byte of 'part' bits, from mosi_q
  task automatic spi_frame(input int n, input int part);
    logic [7:0] m;
    miso_q.delete();
    spi_csn = 1'b0;
    repeat (8) @(negedge HCLK);
    for (int i = 0; i < n; i++) begin
      spi_bits(mosi_q[i], 8, m);
      miso_q.push_back(m);
    end
    if (part > 0) begin
      spi_bits(mosi_q[n], part, m);
      miso_q.push_back(m);
    end
    spi_end();
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    n_checks++; if (spi_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", spi_oe); end
    n_checks++; if (spi_sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo got=%b exp=0", spi_sdo); end
    n_checks++; if (events_o !== 1'b0) begin n_fail++; $display("FAIL reset_events got=%b exp=0", events_o); end
    n_checks++; if (PRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
    n_checks++; if ({PREADY, PSLVERR} !== 2'b10) begin n_fail++; $display("FAIL reset_pready_pslverr got=%b exp=10", {PREADY, PSLVERR}); end
    HRESETn = 1'b1;
    @(negedge HCLK);
    m_clear();
    apb_read(2'd0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", d); end
    apb_read(2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    apb_read(2'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rxdata got=%h exp=0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [7:0]  m;
    apb_write(2'd3, 32'h1);
    tx_write(8'hA5);
    tx_write(8'h3C);
    mosi_q = '{8'h5A, 8'hC3};
    m_frame(2, 0);
    miso_q.delete();
    spi_csn = 1'b0;
    repeat (8) @(negedge HCLK);
    apb_read(2'd0, d);
    n_checks++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", d[0]); end
    for (int i = 0; i < 2; i++) begin
      spi_bits(mosi_q[i], 8, m);
      miso_q.push_back(m);
    end
    spi_end();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (miso_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_sdo[%0d] got=%h exp=%h", i, miso_q[i], exp_q[i]); end
    end
    apb_read(2'd0, d);
    n_checks++; if (d !== m_status() || d[23:16] !== 8'd2) begin n_fail++; $display("FAIL basic_status got=%h exp=%h", d, m_status()); end
    for (int i = 0; i < 2; i++) begin
      apb_read(2'd2, d);
      m = m_rx_pop();
      n_checks++; if (d !== {24'h0, m}) begin n_fail++; $display("FAIL basic_rxdata[%0d] got=%h exp=%h", i, d, m); end
    end
    apb_read(2'd0, d);
    n_checks++; if (d[23:16] !== 8'd0) begin n_fail++; $display("FAIL basic_rxcnt got=%0d exp=0", d[23:16]); end
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    apb_write(2'd0, 32'h1E);
    mflags = '0;
    mosi_q = '{8'($urandom)};
    m_frame(1, 0);
    spi_frame(1, 0);
    n_checks++; if (miso_q[0] !== 8'hFF) begin n_fail++; $display("FAIL udf_sdo got=%h exp=ff", miso_q[0]); end
    apb_read(2'd0, d);
    n_checks++; if (d[2] !== 1'b1 || d !== m_status()) begin n_fail++; $display("FAIL udf_flag got=%h exp=%h", d, m_status()); end
    apb_write(2'd0, 32'h4);
    mflags[1] = 1'b0;
    apb_read(2'd0, d);
    n_checks++; if (d[2] !== 1'b0 || d !== m_status()) begin n_fail++; $display("FAIL udf_w1c got=%h exp=%h", d, m_status()); end
    apb_read(2'd2, d);
    n_checks++; if (d !== {24'h0, m_rx_pop()}) begin n_fail++; $display("FAIL udf_rxdata got=%h", d); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    logic [7:0]  first;
    mosi_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) mosi_q.push_back(8'($urandom));
    first = mosi_q[0];
    m_frame(DEPTH + 1, 0);
    spi_frame(DEPTH + 1, 0);
    apb_read(2'd0, d);
    n_checks++; if (d[23:16] !== 8'(DEPTH) || d[1] !== 1'b1 || d !== m_status()) begin n_fail++; $display("FAIL rxovf_status got=%h exp=%h", d, m_status()); end
    apb_read(2'd2, d);
    n_checks++; if (d !== {24'h0, first}) begin n_fail++; $display("FAIL rxovf_first got=%h exp=%h", d, first); end
    void'(m_rx_pop());
    for (int i = 1; i < DEPTH; i++) begin
      apb_read(2'd2, d);
      n_checks++; if (d !== {24'h0, m_rx_pop()}) begin n_fail++; $display("FAIL rxovf_drain[%0d] got=%h", i, d); end
    end
    apb_read(2'd2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rxovf_empty_read got=%h exp=0", d); end
    apb_write(2'd0, 32'h1E);
    mflags = '0;
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int prev;
    tx_write(8'($urandom));
    tx_write(8'($urandom));
    prev = rxq.size();
    mosi_q = '{8'($urandom), 8'h00};
    m_frame(0, 5);
    spi_frame(0, 5);
    n_checks++; if ((miso_q[0] >> 3) !== (exp_q[0] >> 3)) begin n_fail++; $display("FAIL abort_partial_sdo got=%h exp=%h", miso_q[0], exp_q[0]); end
    apb_read(2'd0, d);
    n_checks++; if (d[3] !== 1'b1 || d[23:16] !== 8'(prev) || d !== m_status()) begin n_fail++; $display("FAIL abort_status got=%h exp=%h", d, m_status()); end
    apb_write(2'd0, 32'h8);
    mflags[2] = 1'b0;
    mosi_q = '{8'($urandom)};
    m_frame(1, 0);
    spi_frame(1, 0);
    n_checks++; if (miso_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL abort_next_sdo got=%h exp=%h", miso_q[0], exp_q[0]); end
    apb_read(2'd2, d);
    n_checks++; if (d !== {24'h0, m_rx_pop()}) begin n_fail++; $display("FAIL abort_next_rx got=%h", d); end
    apb_read(2'd0, d);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL abort_after_status got=%h exp=%h", d, m_status()); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    int n;
    n = DEPTH - txq.size() + 1;
    for (int i = 0; i < n; i++) tx_write(8'($urandom));
    apb_read(2'd0, d);
    n_checks++; if (d[15:8] !== 8'(DEPTH) || d[4] !== 1'b1 || d !== m_status()) begin n_fail++; $display("FAIL txovf_status got=%h exp=%h", d, m_status()); end
    apb_write(2'd0, 32'h10);
    mflags[3] = 1'b0;
    apb_read(2'd0, d);
    n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL txovf_w1c got=%h exp=%h", d, m_status()); end
  endtask

  task automatic test_swrst();
    logic [31:0] d;
    tx_write(8'($urandom));
    apb_write(2'd3, 32'h3);
    m_clear();
    apb_read(2'd0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL swrst_status got=%h exp=0", d); end
    apb_read(2'd3, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL swrst_ctrl got=%h exp=1", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    apb_write(2'd3, 32'h15); // enable, rx_int_en, rx_th=1
    apb_read(2'd3, d);
    n_checks++; if (d !== (IRQ ? 32'h15 : 32'h1)) begin n_fail++; $display("FAIL irq_ctrl got=%h", d); end
    mosi_q = '{8'($urandom)};
    m_frame(1, 0);
    spi_frame(1, 0);
    n_checks++; if (events_o !== 1'b0) begin n_fail++; $display("FAIL irq_one_byte got=%b exp=0", events_o); end
    mosi_q = '{8'($urandom)};
    m_frame(1, 0);
    spi_frame(1, 0);
    n_checks++; if (events_o !== IRQ) begin n_fail++; $display("FAIL irq_two_bytes got=%b exp=%b", events_o, IRQ); end
    apb_read(2'd2, d);
    n_checks++; if (d !== {24'h0, m_rx_pop()}) begin n_fail++; $display("FAIL irq_rxdata got=%h", d); end
    repeat (2) @(negedge HCLK);
    n_checks++; if (events_o !== 1'b0) begin n_fail++; $display("FAIL irq_after_read got=%b exp=0", events_o); end
    apb_write(2'd3, 32'h3);
    m_clear();
  endtask

  task automatic test_random();
    logic [31:0] d;
    int k, n, r;
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(0, 4);
      for (int i = 0; i < k; i++) tx_write(8'($urandom));
      n = $urandom_range(1, 3);
      mosi_q.delete();
      for (int i = 0; i < n; i++) mosi_q.push_back(8'($urandom));
      m_frame(n, 0);
      spi_frame(n, 0);
      for (int i = 0; i < n; i++) begin
        n_checks++; if (miso_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_sdo it%0d[%0d] got=%h exp=%h", it, i, miso_q[i], exp_q[i]); end
      end
      r = $urandom_range(0, rxq.size() + 1);
      for (int i = 0; i < r; i++) begin
        apb_read(2'd2, d);
        n_checks++; if (d !== {24'h0, m_rx_pop()}) begin n_fail++; $display("FAIL rand_rx it%0d got=%h", it, d); end
      end
      apb_read(2'd0, d);
      n_checks++; if (d !== m_status()) begin n_fail++; $display("FAIL rand_status it%0d got=%h exp=%h", it, d, m_status()); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    logic [7:0]  m;
    apb_write(2'd3, 32'h1);
    tx_write(8'($urandom));
    spi_csn = 1'b0;
    repeat (8) @(negedge HCLK);
    spi_bits(8'($urandom), 3, m);
    n_checks++; if (spi_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_oe_before got=%b exp=1", spi_oe); end
    #2 HRESETn = 1'b0;
    #1;
    n_checks++; if (spi_oe !== 1'b0 || spi_sdo !== 1'b0) begin n_fail++; $display("FAIL midrst_async got=%b%b exp=00", spi_oe, spi_sdo); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    spi_csn = 1'b1;
    m_clear();
    repeat (8) @(negedge HCLK);
    apb_read(2'd0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_status got=%h exp=0", d); end
    apb_read(2'd3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_events_quiet();
`ifndef SPI_SLAVE_IRQ_EN
    n_checks++; if (ev_hi !== 0) begin n_fail++; $display("FAIL events_quiet got=%0d cycles high exp=0", ev_hi); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_rx_overflow();
    test_abort();
    test_tx_overflow();
    test_swrst();
    test_irq();
    test_random();
    test_reset_midframe();
    test_events_quiet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
